// File: rtl/rf_bank_arbiter_if.sv
// Request-side bus of the register-file bank arbiter: collector reads and the writeback port.
// The master modport is the requester side, the slave modport is the arbiter side.
interface rf_bank_arbiter_if #(
    parameter int NUM_OC = 8
);
    logic [NUM_OC-1:0]   rd_req_valid;
    logic [2*NUM_OC-1:0] rd_req_bank;
    logic [3*NUM_OC-1:0] rd_req_addr;
    logic [NUM_OC-1:0]   rd_req_ready;
    logic                wb_valid;
    logic [1:0]          wb_bank;
    logic [2:0]          wb_addr;
    logic [7:0]          wb_mask;
    logic [255:0]        wb_data;
    logic                wb_ready;

    modport master (
        output rd_req_valid, rd_req_bank, rd_req_addr,
        output wb_valid, wb_bank, wb_addr, wb_mask, wb_data,
        input  rd_req_ready, wb_ready
    );

    modport slave (
        input  rd_req_valid, rd_req_bank, rd_req_addr,
        input  wb_valid, wb_bank, wb_addr, wb_mask, wb_data,
        output rd_req_ready, wb_ready
    );
endinterface

// File: rtl/rf_bank_arbiter.sv
// Per-bank arbiter for the 4-bank register file: round-robin among collector reads, one
// shared writeback, per-bank starvation counters that force reads, registered RF controls.
module rf_bank_arbiter #(
    parameter int NUM_OC       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    rf_bank_arbiter_if.slave req_if,
    output logic [2:0]       RF_Addr_0,
    output logic [2:0]       RF_Addr_1,
    output logic [2:0]       RF_Addr_2,
    output logic [2:0]       RF_Addr_3,
    output logic             RF_WR_0,
    output logic             RF_WR_1,
    output logic             RF_WR_2,
    output logic             RF_WR_3,
    output logic [7:0]       RF_WR_MASK,
    output logic [255:0]     WriteData,
    output logic [3:0]       ocid_out_0,
    output logic [3:0]       ocid_out_1,
    output logic [3:0]       ocid_out_2,
    output logic [3:0]       ocid_out_3
);
    localparam int         CW        = $clog2(STARVE_LIMIT + 1);
    localparam int         PW        = (NUM_OC > 1) ? $clog2(NUM_OC) : 1;
    localparam logic [3:0] OCID_IDLE = 4'hF;

    logic [PW-1:0]     rr_ptr     [4];
    logic [CW-1:0]     starve_cnt [4];
    logic [NUM_OC-1:0] cand       [4];
    logic [3:0]        rd_pend;
    logic [3:0]        wr_win;
    logic [3:0]        rd_win;
    logic [3:0]        rd_sel     [4];
    logic [2:0]        rd_addr    [4];
    logic [PW-1:0]     rr_next    [4];
    logic [NUM_OC-1:0] rd_ready;

    logic [2:0]        addr_q [4];
    logic [3:0]        wr_q;
    logic [3:0]        ocid_q [4];
    logic [7:0]        mask_q;
    logic [255:0]      data_q;

    always_comb begin
        rd_pend  = '0;
        wr_win   = '0;
        rd_win   = '0;
        rd_ready = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            cand[b]    = '0;
            rd_sel[b]  = OCID_IDLE;
            rd_addr[b] = '0;
            rr_next[b] = rr_ptr[b];
            for (int unsigned i = 0; i < NUM_OC; i++) begin
                cand[b][i] = req_if.rd_req_valid[i] && (req_if.rd_req_bank[2*i +: 2] == 2'(b));
            end
            rd_pend[b] = |cand[b];
            wr_win[b]  = req_if.wb_valid && (req_if.wb_bank == 2'(b)) &&
                         (starve_cnt[b] < CW'(STARVE_LIMIT));
            // Pass 0 scans indices at/after the pointer, pass 1 the wrapped part below it.
            if (!wr_win[b]) begin
                for (int unsigned pass = 0; pass < 2; pass++) begin
                    for (int unsigned i = 0; i < NUM_OC; i++) begin
                        if (!rd_win[b] && cand[b][i] &&
                            ((pass == 0) == (i >= 32'(rr_ptr[b])))) begin
                            rd_win[b]   = 1'b1;
                            rd_sel[b]   = 4'(i);
                            rd_addr[b]  = req_if.rd_req_addr[3*i +: 3];
                            rr_next[b]  = PW'((i + 1) % NUM_OC);
                            rd_ready[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign req_if.rd_req_ready = rst ? rd_ready : '0;
    assign req_if.wb_ready     = rst && (|wr_win);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned b = 0; b < 4; b++) begin
                rr_ptr[b]     <= '0;
                starve_cnt[b] <= '0;
                addr_q[b]     <= '0;
                ocid_q[b]     <= OCID_IDLE;
            end
            wr_q   <= '0;
            mask_q <= '0;
            data_q <= '0;
        end else begin
            mask_q <= '0;
            for (int unsigned b = 0; b < 4; b++) begin
                if (wr_win[b]) begin
                    addr_q[b]     <= req_if.wb_addr;
                    wr_q[b]       <= 1'b1;
                    ocid_q[b]     <= OCID_IDLE;
                    mask_q        <= req_if.wb_mask;
                    data_q        <= req_if.wb_data;
                    starve_cnt[b] <= rd_pend[b] ? starve_cnt[b] + 1'b1 : '0;
                end else if (rd_win[b]) begin
                    addr_q[b]     <= rd_addr[b];
                    wr_q[b]       <= 1'b0;
                    ocid_q[b]     <= rd_sel[b];
                    rr_ptr[b]     <= rr_next[b];
                    starve_cnt[b] <= '0;
                end else begin
                    wr_q[b]       <= 1'b0;
                    ocid_q[b]     <= OCID_IDLE;
                    starve_cnt[b] <= '0;
                end
            end
        end
    end

    assign RF_Addr_0  = addr_q[0];
    assign RF_Addr_1  = addr_q[1];
    assign RF_Addr_2  = addr_q[2];
    assign RF_Addr_3  = addr_q[3];
    assign RF_WR_0    = wr_q[0];
    assign RF_WR_1    = wr_q[1];
    assign RF_WR_2    = wr_q[2];
    assign RF_WR_3    = wr_q[3];
    assign RF_WR_MASK = mask_q;
    assign WriteData  = data_q;
    assign ocid_out_0 = ocid_q[0];
    assign ocid_out_1 = ocid_q[1];
    assign ocid_out_2 = ocid_q[2];
    assign ocid_out_3 = ocid_q[3];
endmodule

// File: tb/tb_rf_bank_arbiter.sv
// Bench for rf_bank_arbiter: directed scenarios plus randomized traffic compared against a
// behavioural model of the per-bank arbitration, starvation and issue rules.
module tb_rf_bank_arbiter;
    localparam int NUM_OC       = 8;
    localparam int STARVE_LIMIT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rf_bank_arbiter_if #(.NUM_OC(NUM_OC)) bus ();

    logic [2:0]   rf_addr [4];
    logic [3:0]   rf_wr;
    logic [3:0]   ocid    [4];
    logic [7:0]   rf_mask;
    logic [255:0] wdata;

    rf_bank_arbiter #(.NUM_OC(NUM_OC), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst), .req_if(bus),
        .RF_Addr_0(rf_addr[0]), .RF_Addr_1(rf_addr[1]), .RF_Addr_2(rf_addr[2]), .RF_Addr_3(rf_addr[3]),
        .RF_WR_0(rf_wr[0]), .RF_WR_1(rf_wr[1]), .RF_WR_2(rf_wr[2]), .RF_WR_3(rf_wr[3]),
        .RF_WR_MASK(rf_mask), .WriteData(wdata),
        .ocid_out_0(ocid[0]), .ocid_out_1(ocid[1]), .ocid_out_2(ocid[2]), .ocid_out_3(ocid[3])
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model state and expectations
    int           m_rr     [4];
    int           m_starve [4];
    logic [2:0]   e_addr   [4];
    logic [3:0]   e_wr;
    logic [3:0]   e_ocid   [4];
    logic [7:0]   e_mask;
    logic [255:0] e_data;
    logic [NUM_OC-1:0] e_rdy;
    logic         e_wbrdy;
    int           g_winner [4];
    bit           g_write  [4];
    bit           g_pend   [4];
    logic [2:0]   g_addr   [4];
    logic [7:0]   g_mask;
    logic [255:0] g_data;

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            m_rr[b] = 0; m_starve[b] = 0; e_addr[b] = '0; e_ocid[b] = 4'hF;
        end
        e_wr = '0; e_mask = '0; e_data = '0; e_rdy = '0; e_wbrdy = 1'b0;
    endtask

    // Winner = pending collector with the smallest circular distance from the bank's pointer.
    task automatic model_eval();
        int best, d;
        e_rdy = '0; e_wbrdy = 1'b0;
        g_mask = bus.wb_mask; g_data = bus.wb_data;
        for (int b = 0; b < 4; b++) begin
            g_pend[b] = 0; g_write[b] = 0; g_winner[b] = -1; best = NUM_OC;
            for (int i = 0; i < NUM_OC; i++) begin
                if (bus.rd_req_valid[i] && bus.rd_req_bank[2*i +: 2] == 2'(b)) begin
                    g_pend[b] = 1;
                    d = (i - m_rr[b] + NUM_OC) % NUM_OC;
                    if (d < best) begin best = d; g_winner[b] = i; end
                end
            end
            if (bus.wb_valid && bus.wb_bank == 2'(b) && m_starve[b] < STARVE_LIMIT) begin
                g_write[b] = 1; g_winner[b] = -1; e_wbrdy = 1'b1; g_addr[b] = bus.wb_addr;
            end else if (g_winner[b] >= 0) begin
                e_rdy[g_winner[b]] = 1'b1;
                g_addr[b] = bus.rd_req_addr[3*g_winner[b] +: 3];
            end
        end
        if (!rst) begin e_rdy = '0; e_wbrdy = 1'b0; end
    endtask

    task automatic model_commit();
        bit any_write = 0;
        for (int b = 0; b < 4; b++) begin
            if (g_write[b]) begin
                any_write = 1; e_addr[b] = g_addr[b]; e_wr[b] = 1'b1; e_ocid[b] = 4'hF;
                e_mask = g_mask; e_data = g_data;
                m_starve[b] = g_pend[b] ? ((m_starve[b] + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_starve[b] + 1) : 0;
            end else if (g_winner[b] >= 0) begin
                e_addr[b] = g_addr[b]; e_wr[b] = 1'b0; e_ocid[b] = 4'(g_winner[b]);
                m_rr[b] = (g_winner[b] + 1) % NUM_OC; m_starve[b] = 0;
            end else begin
                e_wr[b] = 1'b0; e_ocid[b] = 4'hF; m_starve[b] = 0;
            end
        end
        if (!any_write) e_mask = '0;
    endtask

    task automatic sample_point();
        @(negedge clk);
        model_eval();
    endtask

    task automatic clock_edge();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic set_rd(input int i, input bit v, input int bank, input int addr);
        bus.rd_req_valid[i]      = v;
        bus.rd_req_bank[2*i +: 2] = 2'(bank);
        bus.rd_req_addr[3*i +: 3] = 3'(addr);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.rd_req_valid = '0; bus.rd_req_bank = '0; bus.rd_req_addr = '0;
        bus.wb_valid = 1'b0; bus.wb_bank = '0; bus.wb_addr = '0; bus.wb_mask = '0; bus.wb_data = '0;
        model_reset();
        set_rd(0, 1, 1, 5);
        bus.wb_valid = 1'b1;
        #12;
        compared++;
        if (bus.rd_req_ready !== '0 || bus.wb_ready !== 1'b0) begin
            mismatched++; $display("FAIL reset_ready: got rd=%b wb=%b want 0/0", bus.rd_req_ready, bus.wb_ready);
        end
        compared++;
        if (rf_wr !== 4'h0 || rf_mask !== 8'h00 || wdata !== '0) begin
            mismatched++; $display("FAIL reset_wr: got wr=%b mask=%h want 0/00 data zero", rf_wr, rf_mask);
        end
        for (int b = 0; b < 4; b++) begin
            compared++;
            if (ocid[b] !== 4'hF || rf_addr[b] !== 3'd0) begin
                mismatched++; $display("FAIL reset_bank%0d: got ocid=%h addr=%0d want F/0", b, ocid[b], rf_addr[b]);
            end
        end
        @(negedge clk);
        bus.rd_req_valid = '0; bus.wb_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_read();
        set_rd(0, 1, 1, 5);
        sample_point();
        compared++;
        if (bus.rd_req_ready !== 8'h01 || e_rdy !== 8'h01) begin
            mismatched++; $display("FAIL single_ready: got %b model %b want 00000001", bus.rd_req_ready, e_rdy);
        end
        clock_edge();
        set_rd(0, 0, 1, 5);
        compared++;
        if (rf_addr[1] !== 3'd5 || ocid[1] !== 4'd0 || rf_wr[1] !== 1'b0) begin
            mismatched++; $display("FAIL single_issue: got addr=%0d ocid=%h wr=%b want 5/0/0", rf_addr[1], ocid[1], rf_wr[1]);
        end
    endtask

    task automatic test_round_robin();
        int exp_w [5] = '{1, 3, 6, 7, 6};
        set_rd(1, 1, 2, 1); set_rd(3, 1, 2, 3); set_rd(6, 1, 2, 6);
        for (int k = 0; k < 5; k++) begin
            if (k == 3) set_rd(7, 1, 2, 7);
            if (k == 3) set_rd(6, 1, 2, 4);
            sample_point();
            compared++;
            if (bus.rd_req_ready !== (8'h01 << exp_w[k]) || bus.rd_req_ready !== e_rdy) begin
                mismatched++; $display("FAIL rr_ready%0d: got %b model %b want OC%0d", k, bus.rd_req_ready, e_rdy, exp_w[k]);
            end
            clock_edge();
            compared++;
            if (ocid[2] !== 4'(exp_w[k]) || rf_addr[2] !== e_addr[2]) begin
                mismatched++; $display("FAIL rr_issue%0d: got ocid=%h addr=%0d want %0d/%0d", k, ocid[2], rf_addr[2], exp_w[k], e_addr[2]);
            end
            bus.rd_req_valid[exp_w[k]] = 1'b0;
        end
    endtask

    task automatic test_all_banks();
        for (int i = 0; i < 4; i++) set_rd(i, 1, i, i + 1);
        sample_point();
        compared++;
        if (bus.rd_req_ready !== 8'h0F) begin
            mismatched++; $display("FAIL all_ready: got %b want 00001111", bus.rd_req_ready);
        end
        clock_edge();
        bus.rd_req_valid = '0;
        for (int b = 0; b < 4; b++) begin
            compared++;
            if (ocid[b] !== 4'(b) || rf_addr[b] !== 3'(b + 1)) begin
                mismatched++; $display("FAIL all_issue%0d: got ocid=%h addr=%0d want %0d/%0d", b, ocid[b], rf_addr[b], b, b + 1);
            end
        end
    endtask

    task automatic test_starvation();
        bit exp_wb [6] = '{1, 1, 1, 1, 0, 1};
        logic [255:0] d = rand256();
        bus.wb_valid = 1'b1; bus.wb_bank = 2'd0; bus.wb_addr = 3'd2; bus.wb_mask = 8'hA5; bus.wb_data = d;
        set_rd(4, 1, 0, 6);
        for (int k = 0; k < 6; k++) begin
            sample_point();
            compared++;
            if (bus.wb_ready !== exp_wb[k] || bus.rd_req_ready[4] !== !exp_wb[k] || bus.wb_ready !== e_wbrdy) begin
                mismatched++; $display("FAIL starve_grant%0d: got wb=%b rd4=%b want wb=%b", k, bus.wb_ready, bus.rd_req_ready[4], exp_wb[k]);
            end
            clock_edge();
            if (!exp_wb[k]) bus.rd_req_valid[4] = 1'b0;
            compared++;
            if (exp_wb[k] && (rf_wr[0] !== 1'b1 || rf_mask !== 8'hA5 || rf_addr[0] !== 3'd2 || wdata !== d)) begin
                mismatched++; $display("FAIL starve_wr%0d: got wr=%b mask=%h addr=%0d want 1/a5/2", k, rf_wr[0], rf_mask, rf_addr[0]);
            end else if (!exp_wb[k] && (rf_wr[0] !== 1'b0 || ocid[0] !== 4'd4 || rf_mask !== 8'h00 || rf_addr[0] !== 3'd6)) begin
                mismatched++; $display("FAIL starve_rd%0d: got wr=%b ocid=%h mask=%h want 0/4/00", k, rf_wr[0], ocid[0], rf_mask);
            end
        end
        bus.wb_valid = 1'b0;
    endtask

    task automatic test_write_and_read();
        logic [255:0] d = rand256();
        bus.wb_valid = 1'b1; bus.wb_bank = 2'd3; bus.wb_addr = 3'd1; bus.wb_mask = 8'h3C; bus.wb_data = d;
        set_rd(2, 1, 1, 7);
        sample_point();
        compared++;
        if (bus.wb_ready !== 1'b1 || bus.rd_req_ready !== 8'h04) begin
            mismatched++; $display("FAIL wr_rd_ready: got wb=%b rd=%b want 1/00000100", bus.wb_ready, bus.rd_req_ready);
        end
        clock_edge();
        bus.wb_valid = 1'b0; bus.rd_req_valid = '0;
        compared++;
        if (rf_wr !== 4'b1000 || ocid[3] !== 4'hF || ocid[1] !== 4'd2 || rf_addr[1] !== 3'd7 ||
            rf_addr[3] !== 3'd1 || rf_mask !== 8'h3C || wdata !== d) begin
            mismatched++; $display("FAIL wr_rd_issue: got wr=%b ocid3=%h ocid1=%h mask=%h want 1000/f/2/3c", rf_wr, ocid[3], ocid[1], rf_mask);
        end
    endtask

    task automatic drive_random();
        for (int i = 0; i < NUM_OC; i++) begin
            if (bus.rd_req_valid[i] && !e_rdy[i]) continue;
            if ($urandom_range(0, 99) < 45) set_rd(i, 1, $urandom_range(0, 3), $urandom_range(0, 7));
            else bus.rd_req_valid[i] = 1'b0;
        end
        if (!bus.wb_valid || e_wbrdy) begin
            bus.wb_valid = ($urandom_range(0, 99) < 60);
            bus.wb_bank  = 2'($urandom_range(0, 3));
            bus.wb_addr  = 3'($urandom_range(0, 7));
            bus.wb_mask  = 8'($urandom);
            bus.wb_data  = rand256();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive_random();
            sample_point();
            compared++;
            if (bus.rd_req_ready !== e_rdy || bus.wb_ready !== e_wbrdy) begin
                mismatched++; $display("FAIL rand_ready c%0d: got rd=%b wb=%b want rd=%b wb=%b", c, bus.rd_req_ready, bus.wb_ready, e_rdy, e_wbrdy);
            end
            clock_edge();
            for (int b = 0; b < 4; b++) begin
                compared++;
                if (rf_addr[b] !== e_addr[b] || rf_wr[b] !== e_wr[b] || ocid[b] !== e_ocid[b]) begin
                    mismatched++; $display("FAIL rand_bank%0d c%0d: got addr=%0d wr=%b ocid=%h want %0d/%b/%h", b, c, rf_addr[b], rf_wr[b], ocid[b], e_addr[b], e_wr[b], e_ocid[b]);
                end
            end
            compared++;
            if (rf_mask !== e_mask || wdata !== e_data) begin
                mismatched++; $display("FAIL rand_wdata c%0d: got mask=%h want %h", c, rf_mask, e_mask);
            end
        end
        bus.rd_req_valid = '0; bus.wb_valid = 1'b0;
        sample_point();
        clock_edge();
    endtask

    task automatic test_async_reset();
        int exp_w [2] = '{0, 5};
        set_rd(5, 1, 0, 3); set_rd(1, 1, 2, 4);
        bus.wb_valid = 1'b1; bus.wb_bank = 2'd3; bus.wb_addr = 3'd6; bus.wb_mask = 8'hFF; bus.wb_data = rand256();
        sample_point();
        clock_edge();
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        compared++;
        if (bus.rd_req_ready !== '0 || bus.wb_ready !== 1'b0) begin
            mismatched++; $display("FAIL arst_ready: got rd=%b wb=%b want 0/0", bus.rd_req_ready, bus.wb_ready);
        end
        compared++;
        if (rf_wr !== 4'h0 || rf_mask !== 8'h00 || wdata !== '0 || ocid[0] !== 4'hF || ocid[2] !== 4'hF ||
            rf_addr[0] !== 3'd0 || rf_addr[2] !== 3'd0 || rf_addr[3] !== 3'd0) begin
            mismatched++; $display("FAIL arst_outputs: got wr=%b mask=%h ocid0=%h ocid2=%h want 0/00/f/f", rf_wr, rf_mask, ocid[0], ocid[2]);
        end
        @(posedge clk); #1;
        compared++;
        if (rf_wr !== 4'h0 || ocid[0] !== 4'hF || bus.rd_req_ready !== '0) begin
            mismatched++; $display("FAIL arst_hold: got wr=%b ocid0=%h rd=%b want 0/f/0", rf_wr, ocid[0], bus.rd_req_ready);
        end
        model_reset();
        bus.rd_req_valid = '0; bus.wb_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        // Pointer for bank 0 is back at 0, so OC0 beats OC5.
        set_rd(5, 1, 0, 3); set_rd(0, 1, 0, 2);
        for (int k = 0; k < 2; k++) begin
            sample_point();
            compared++;
            if (bus.rd_req_ready !== (8'h01 << exp_w[k]) || bus.rd_req_ready !== e_rdy) begin
                mismatched++; $display("FAIL arst_rr%0d: got %b model %b want OC%0d", k, bus.rd_req_ready, e_rdy, exp_w[k]);
            end
            clock_edge();
            bus.rd_req_valid[exp_w[k]] = 1'b0;
            compared++;
            if (ocid[0] !== 4'(exp_w[k])) begin
                mismatched++; $display("FAIL arst_issue%0d: got ocid=%h want %0d", k, ocid[0], exp_w[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_all_banks();
        test_starvation();
        test_write_and_read();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/rf_bank_arbiter.md
Name: rf_bank_arbiter

Overview:
- Schedules the 4-bank register file. Shares the banks between NUM_OC operand-collector read requesters and a single writeback port.
- Per cycle and per bank, it grants at most one access, either one read or the write.
- At most one write is issued per cycle across all banks, because the register file has a single shared write mask.
- All register-file control outputs are registered. Read data and its collector tag come back from the register file one cycle after issue.

Parameters:
- NUM_OC, 8, number of operand-collector requesters (1..15); ocid 4'hF is reserved as the idle tag.
- STARVE_LIMIT, 4, number of consecutive write wins on a bank, with a read pending on that bank, after which reads are forced.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- rd_req_valid  in  NUM_OC  read request per collector.
- rd_req_bank  in  2*NUM_OC  target bank per collector; slice [2i+1:2i].
- rd_req_addr  in  3*NUM_OC  register row per collector; slice [3i+2:3i].
- rd_req_ready  out  NUM_OC  combinational grant; the transfer happens when valid and ready are both high.
- wb_valid  in  1  writeback request.
- wb_bank  in  2  target bank of the writeback.
- wb_addr  in  3  target row of the writeback.
- wb_mask  in  8  per-lane write mask.
- wb_data  in  256  write data.
- wb_ready  out  1  combinational writeback grant.
- RF_Addr_0..RF_Addr_3  out  3 each  registered bank address.
- RF_WR_0..RF_WR_3  out  1 each  registered bank write enable.
- RF_WR_MASK  out  8  registered write mask, shared by all banks.
- WriteData  out  256  registered write data; fans out to WriteData_0..3.
- ocid_out_0..ocid_out_3  out  4 each  registered collector tag of the issued read; 4'hF means idle or write.

Behaviour:
- Reset (rst=0, asynchronous): the following hold until rst rises.
  - Outputs: RF_Addr_*=0, RF_WR_*=0, RF_WR_MASK=0, WriteData=0, ocid_out_*=4'hF.
  - Internal state: round-robin pointers=0, starvation counters=0.
  - Handshakes: rd_req_ready=0 and wb_ready=0.
- Per-bank arbitration (combinational, every cycle):
  - Write wins bank b when wb_valid=1, wb_bank=b, and starve_cnt[b] < STARVE_LIMIT. Then wb_ready=1 and no read is granted on bank b.
  - Otherwise the read candidates are the collectors with valid=1 and bank=b.
  - The winner is the first candidate at or after rr_ptr[b] in ascending index order, wrapping from NUM_OC-1 to 0. Only the winner sees ready=1.
  - At most one ready per requester per cycle; each collector targets a single bank.
- Forced-read mode: when starve_cnt[b] == STARVE_LIMIT and a read is pending on bank b, the read wins and wb_ready=0. The write stalls.
- Starvation counter, per bank, updated at the clock edge:
  - Increments, saturating at STARVE_LIMIT, when the write wins bank b while any read is pending on b.
  - Clears when a read is granted on b, or when no read is pending on b.
- Round-robin pointer update: on a read grant to collector i on bank b, rr_ptr[b] <= (i+1) mod NUM_OC. A write grant does not move the pointer.
- Issue registers, updated at the edge after the grant:
  - Read on bank b: RF_Addr_b <= rd_req_addr[i], RF_WR_b <= 0, ocid_out_b <= i.
  - Write on bank b: RF_Addr_b <= wb_addr, RF_WR_b <= 1, RF_WR_MASK <= wb_mask, WriteData <= wb_data, ocid_out_b <= 4'hF.
  - Idle bank: RF_WR_b <= 0, ocid_out_b <= 4'hF, RF_Addr_b holds its value.
  - No write this cycle: RF_WR_MASK <= 0, WriteData holds its value.
- Latency:
  - A request granted in cycle T is issued on the outputs in T+1.
  - The register file returns DataOut_b and ocid_b in T+2.
  - Back-to-back grants are allowed on the same bank every cycle.
- Requester contract: bank, address, write mask and write data must stay stable while valid=1 and ready=0. Valid must not drop before the grant. The arbiter does not check this.
- Simultaneous events: reads on four different banks plus a write to a fifth-used bank cannot occur, since there are only 4 banks. Four reads to distinct banks are all granted in the same cycle. A write plus reads on the other three banks are all granted in the same cycle.
- Reset mid-operation: pending grants are dropped and the issue registers take their reset values immediately. Requesters re-present their requests after reset.

Test Plan:
1. After reset: all ocid_out_*=4'hF, RF_WR_*=0, RF_WR_MASK=0. Then OC0 requests bank1 row5 -> rd_req_ready[0]=1 the same cycle; next cycle RF_Addr_1=5, ocid_out_1=0, RF_WR_1=0.
2. OC1, OC3 and OC6 all hold requests to bank2 for 3 cycles, rr_ptr[2]=0 -> grants in order 1, 3, 6; ocid_out_2 sequence 1, 3, 6; rr_ptr[2] ends at 7.
3. OC0, OC1, OC2 and OC3 request banks 0, 1, 2 and 3 simultaneously -> all four ready in one cycle; next cycle ocid_out_0..3 = 0, 1, 2, 3.
4. wb_valid to bank0 row2, wb_mask=8'hA5, held continuously, with OC4 holding a read on bank0, STARVE_LIMIT=4 -> writes win 4 cycles, cycle 5 grants OC4 with wb_ready=0, cycle 6 the write wins again. Write issues show RF_WR_0=1, RF_WR_MASK=8'hA5.
5. Write to bank3 plus an OC2 read on bank1 in the same cycle -> both granted. Next cycle: RF_WR_3=1, ocid_out_3=4'hF, ocid_out_1=2.
6. Assert rst=0 asynchronously, mid-cycle, while grants are pending -> outputs go to reset values immediately without waiting for a clock edge; rd_req_ready=0 and wb_ready=0 while rst=0.
